// File: rtl/teclado_matriz_if.sv
// Keypad bus: row sense lines in, column drive and key event outputs.
// master = scanning controller, slave = keypad/consumer side.
interface teclado_matriz_if #(
   parameter int N_FILAS = 4,
   parameter int N_COLS  = 4
);
   localparam int CODE_W = $clog2(N_FILAS * N_COLS);

   logic [N_FILAS-1:0] filas;
   logic [N_COLS-1:0]  columnas;
   logic [CODE_W-1:0]  tecla_codigo;
   logic               tecla_valida;
   logic               tecla_presionada;
   logic               tecla_liberada;

   modport master (
      input  filas,
      output columnas,
      output tecla_codigo,
      output tecla_valida,
      output tecla_presionada,
      output tecla_liberada
   );

   modport slave (
      output filas,
      input  columnas,
      input  tecla_codigo,
      input  tecla_valida,
      input  tecla_presionada,
      input  tecla_liberada
   );
endinterface

// File: rtl/teclado_matriz.sv
// Matrix keypad scanner: drives one-cold columns, senses active-low rows
// through a 2-flop synchronizer, debounces press and release of a single
// key and reports its code with press/release strobes and a held level.
module teclado_matriz #(
   parameter int N_FILAS      = 4,
   parameter int N_COLS       = 4,
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CYC = 8
) (
   input  logic             clk,
   input  logic             rst,
   teclado_matriz_if.master kbd
);
   localparam int CODE_W = $clog2(N_FILAS * N_COLS);
   localparam int ROW_W  = $clog2(N_FILAS);
   localparam int COL_W  = $clog2(N_COLS);
   localparam int DIV_W  = $clog2(SCAN_DIV);
   localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } estado_t;

   // One-cold drive pattern for a column index
   function automatic logic [N_COLS-1:0] f_drive(input logic [COL_W-1:0] col);
      f_drive = ~(N_COLS'(1) << col);
   endfunction

   // Next column in scan order, wrapping to column 0
   function automatic logic [COL_W-1:0] f_col_sig(input logic [COL_W-1:0] col);
      f_col_sig = (col == COL_LAST) ? '0 : col + COL_W'(1);
   endfunction

   estado_t            r_estado;
   logic [N_FILAS-1:0] r_filas_m;
   logic [N_FILAS-1:0] r_filas_s;
   logic [COL_W-1:0]   r_col_p1;
   logic [COL_W-1:0]   r_col_p2;
   logic [COL_W-1:0]   r_col;
   logic [DIV_W-1:0]   r_div;
   logic [CNT_W-1:0]   r_cnt;
   logic [ROW_W-1:0]   r_fila;
   logic [N_FILAS-1:0] r_patron;
   logic [N_COLS-1:0]  r_columnas;
   logic [CODE_W-1:0]  r_codigo;
   logic               r_valida;
   logic               r_presionada;
   logic               r_liberada;

   logic [N_FILAS-1:0] w_bajos;
   logic               w_una;
   logic [ROW_W-1:0]   w_fila;
   logic               w_fila_alta;
   logic               w_col_ok;
   logic [COL_W-1:0]   w_col_sig;
   logic [CODE_W-1:0]  w_codigo;

   assign w_bajos     = ~r_filas_s;
   assign w_una       = (w_bajos != '0) && ((w_bajos & (w_bajos - N_FILAS'(1))) == '0);
   assign w_fila_alta = r_filas_s[r_fila];
   // r_col_p2 is the column that was driven when r_filas_s was captured at
   // the pins, so the sensed rows belong to r_col only when they agree.
   assign w_col_ok    = (r_col_p2 == r_col);
   assign w_col_sig   = f_col_sig(r_col);
   assign w_codigo    = CODE_W'(int'(r_fila) * N_COLS + int'(r_col));

   // Index of the (single) low row in the synchronized sample
   always_comb begin
      w_fila = '0;
      for (int r = 0; r < N_FILAS; r++) begin
         if (w_bajos[r]) w_fila = ROW_W'(r);
      end
   end

   // Row synchronizer plus column-index delay line aligned with it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filas_m <= '1;
         r_filas_s <= '1;
         r_col_p1  <= '0;
         r_col_p2  <= '0;
      end else begin
         r_filas_m <= kbd.filas;
         r_filas_s <= r_filas_m;
         r_col_p1  <= r_col;
         r_col_p2  <= r_col_p1;
      end
   end

   // Scan / debounce / pressed / release state machine with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado     <= SCAN;
         r_col        <= '0;
         r_div        <= '0;
         r_cnt        <= '0;
         r_fila       <= '0;
         r_patron     <= '1;
         r_columnas   <= f_drive('0);
         r_codigo     <= '0;
         r_valida     <= 1'b0;
         r_presionada <= 1'b0;
         r_liberada   <= 1'b0;
      end else begin
         r_valida   <= 1'b0;
         r_liberada <= 1'b0;
         case (r_estado)
            SCAN: begin
               if (r_div != DIV_LAST) begin
                  r_div <= r_div + DIV_W'(1);
               end else begin
                  r_div <= '0;
                  if (w_una) begin
                     // Attribute the sample to the column that produced it;
                     // with short dwell that is the previous column.
                     r_fila     <= w_fila;
                     r_patron   <= r_filas_s;
                     r_cnt      <= '0;
                     r_col      <= r_col_p2;
                     r_columnas <= f_drive(r_col_p2);
                     r_estado   <= DEBOUNCE;
                  end else begin
                     r_col      <= w_col_sig;
                     r_columnas <= f_drive(w_col_sig);
                  end
               end
            end
            DEBOUNCE: begin
               // Rows still reflecting another column are neither matches
               // nor mismatches; just wait for the pipeline to catch up.
               if (w_col_ok) begin
                  if (r_filas_s != r_patron) begin
                     r_cnt      <= '0;
                     r_div      <= '0;
                     r_col      <= w_col_sig;
                     r_columnas <= f_drive(w_col_sig);
                     r_estado   <= SCAN;
                  end else if (r_cnt == CNT_LAST) begin
                     r_cnt        <= '0;
                     r_codigo     <= w_codigo;
                     r_valida     <= 1'b1;
                     r_presionada <= 1'b1;
                     r_estado     <= PRESSED;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            PRESSED: begin
               if (w_fila_alta) begin
                  r_cnt    <= '0;
                  r_estado <= RELEASE;
               end
            end
            RELEASE: begin
               if (!w_fila_alta) begin
                  r_cnt    <= '0;
                  r_estado <= PRESSED;
               end else if (r_cnt == CNT_LAST) begin
                  r_cnt        <= '0;
                  r_div        <= '0;
                  r_presionada <= 1'b0;
                  r_liberada   <= 1'b1;
                  r_col        <= w_col_sig;
                  r_columnas   <= f_drive(w_col_sig);
                  r_estado     <= SCAN;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_estado <= SCAN;
         endcase
      end
   end

   assign kbd.columnas         = r_columnas;
   assign kbd.tecla_codigo     = r_codigo;
   assign kbd.tecla_valida     = r_valida;
   assign kbd.tecla_presionada = r_presionada;
   assign kbd.tecla_liberada   = r_liberada;
endmodule

// File: tb/tb_teclado_matriz.sv
// Bench for teclado_matriz: a 4x4 default instance and a 2x3 fast-scan
// instance, each wired to a behavioural keypad (key closes row to column).
module tb_teclado_matriz;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   teclado_matriz_if #(.N_FILAS(4), .N_COLS(4)) ifa ();
   teclado_matriz_if #(.N_FILAS(2), .N_COLS(3)) ifb ();

   teclado_matriz #(.N_FILAS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .kbd (ifa.master)
   );

   teclado_matriz #(.N_FILAS(2), .N_COLS(3), .SCAN_DIV(2), .DEBOUNCE_CYC(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .kbd (ifb.master)
   );

   // Keypad models: keys_x[row][col] closed pulls that row low while its
   // column is driven low; force_a pulls a row low unconditionally.
   logic [3:0][3:0] keys_a;
   logic [3:0]      force_a;
   logic [1:0][2:0] keys_b;
   logic [3:0]      low_a;
   logic [1:0]      low_b;

   always_comb begin
      low_a = force_a;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys_a[r][c] && !ifa.columnas[c]) low_a[r] = 1'b1;
   end
   assign ifa.filas = ~low_a;

   always_comb begin
      low_b = '0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 3; c++)
            if (keys_b[r][c] && !ifb.columnas[c]) low_b[r] = 1'b1;
   end
   assign ifb.filas = ~low_b;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Event monitors: press codes, release count, rule violations
   bit mon_on = 1'b0;
   int q_a[$];
   int q_b[$];
   int rel_a = 0, rel_b = 0, viol_a = 0, viol_b = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (ifa.tecla_valida) q_a.push_back(int'(ifa.tecla_codigo));
         if (ifa.tecla_liberada) rel_a++;
         if (ifa.tecla_valida && ifa.tecla_liberada) viol_a++;
         if (ifa.tecla_valida && !ifa.tecla_presionada) viol_a++;
         if (ifa.tecla_liberada && ifa.tecla_presionada) viol_a++;
         if ($countones(~ifa.columnas) != 1) viol_a++;
         if (ifb.tecla_valida) q_b.push_back(int'(ifb.tecla_codigo));
         if (ifb.tecla_liberada) rel_b++;
         if (ifb.tecla_valida && ifb.tecla_liberada) viol_b++;
         if (ifb.tecla_valida && !ifb.tecla_presionada) viol_b++;
         if (ifb.tecla_liberada && ifb.tecla_presionada) viol_b++;
         if ($countones(~ifb.columnas) != 1) viol_b++;
      end
   end

   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Count negedges the current column of a stays driven; report the next one
   task automatic dwell_a(output int n, output logic [3:0] sig);
      logic [3:0] cur;
      cur = ifa.columnas;
      n = 0;
      while (ifa.columnas == cur && n < 200) begin
         n++;
         @(negedge clk);
      end
      sig = ifa.columnas;
   endtask

   task automatic dwell_b(output int n, output logic [2:0] sig);
      logic [2:0] cur;
      cur = ifb.columnas;
      n = 0;
      while (ifb.columnas == cur && n < 200) begin
         n++;
         @(negedge clk);
      end
      sig = ifb.columnas;
   endtask

   // Wait (bounded) until columnas of a equals / differs from v
   task automatic esperar_col_a(input logic [3:0] v, input bit igual, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if ((ifa.columnas == v) == igual) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Release with optional bounce: high h, low l, then high for good
   task automatic soltar_a(input int r, input int c, input int h, input int l);
      keys_a[r][c] = 1'b0;
      if (h > 0) begin
         ciclos(h);
         keys_a[r][c] = 1'b1;
         ciclos(l);
         keys_a[r][c] = 1'b0;
      end
      ciclos(40);
   endtask

   task automatic soltar_b(input int r, input int c, input int h, input int l);
      keys_b[r][c] = 1'b0;
      if (h > 0) begin
         ciclos(h);
         keys_b[r][c] = 1'b1;
         ciclos(l);
         keys_b[r][c] = 1'b0;
      end
      ciclos(40);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, bq, br, r, c, nb, h, l;
      logic [3:0] s4, prev4;
      logic [2:0] s3, prev3;
      bit ok;

      rst = 1'b1;
      keys_a = '0;
      force_a = '0;
      keys_b = '0;
      ciclos(3);

      // Reset values
      chk("rst_col_a", int'(ifa.columnas), 'hE);
      chk("rst_code_a", int'(ifa.tecla_codigo), 0);
      chk("rst_val_a", int'(ifa.tecla_valida), 0);
      chk("rst_pres_a", int'(ifa.tecla_presionada), 0);
      chk("rst_lib_a", int'(ifa.tecla_liberada), 0);
      chk("rst_col_b", int'(ifb.columnas), 'h6);
      chk("rst_code_b", int'(ifb.tecla_codigo), 0);
      mon_on = 1'b1;

      // First column advance SCAN_DIV cycles after reset release
      rst = 1'b0;
      dwell_a(n, s4);
      chk("first_dwell_a", n, 4);
      chk("first_next_a", int'(s4), 'hD);
      dwell_a(n, s4);
      chk("dwell_col1_a", n, 4);
      dwell_b(n, s3);
      dwell_b(n, s3);
      chk("dwell_b", n, 2);

      // Key row 2 / col 1 -> code 9
      bq = q_a.size(); br = rel_a;
      keys_a[2][1] = 1'b1;
      ciclos(80);
      chk("k9_presses", q_a.size() - bq, 1);
      chk("k9_code", (q_a.size() > bq) ? q_a[q_a.size()-1] : -1, 9);
      chk("k9_out_code", int'(ifa.tecla_codigo), 9);
      chk("k9_pres", int'(ifa.tecla_presionada), 1);
      soltar_a(2, 1, 0, 0);
      chk("k9_rel", rel_a - br, 1);
      chk("k9_pres_off", int'(ifa.tecla_presionada), 0);
      chk("k9_code_hold", int'(ifa.tecla_codigo), 9);
      chk("k9_no_2nd", q_a.size() - bq, 1);

      // Row-0 glitch of DEBOUNCE_CYC-1 cycles while column 3 is driven
      bq = q_a.size();
      esperar_col_a(4'b0111, 1'b0, ok);
      chk("glitch_wait1", int'(ok), 1);
      esperar_col_a(4'b0111, 1'b1, ok);
      chk("glitch_wait2", int'(ok), 1);
      force_a[0] = 1'b1;
      ciclos(7);
      force_a[0] = 1'b0;
      dwell_a(n, s4);
      chk("glitch_next", int'(s4), 'hE);
      dwell_a(n, s4);
      chk("glitch_dwell0", n, 4);
      ciclos(30);
      chk("glitch_nopress", q_a.size() - bq, 0);

      // Ghost: rows 1 and 3 on column 2 together
      bq = q_a.size();
      keys_a[1][2] = 1'b1;
      keys_a[3][2] = 1'b1;
      dwell_a(n, s4);
      for (int i = 0; i < 8; i++) begin
         prev4 = ifa.columnas;
         dwell_a(n, s4);
         chk("ghost_dwell", n, 4);
         chk("ghost_seq", int'(s4), int'({prev4[2:0], prev4[3]}));
      end
      chk("ghost_nopress", q_a.size() - bq, 0);
      keys_a[1][2] = 1'b0;
      keys_a[3][2] = 1'b0;
      ciclos(20);

      // Release bounce: high 3, low 2, high
      bq = q_a.size(); br = rel_a;
      keys_a[0][3] = 1'b1;
      ciclos(80);
      chk("bnc_code", (q_a.size() > bq) ? q_a[q_a.size()-1] : -1, 3);
      soltar_a(0, 3, 3, 2);
      chk("bnc_rel", rel_a - br, 1);
      chk("bnc_presses", q_a.size() - bq, 1);

      // Reset while pressed, key still held
      bq = q_a.size(); br = rel_a;
      keys_a[1][1] = 1'b1;
      ciclos(80);
      chk("mrst_first", (q_a.size() > bq) ? q_a[q_a.size()-1] : -1, 5);
      rst = 1'b1;
      ciclos(1);
      chk("mrst_col", int'(ifa.columnas), 'hE);
      chk("mrst_code", int'(ifa.tecla_codigo), 0);
      chk("mrst_val", int'(ifa.tecla_valida), 0);
      chk("mrst_pres", int'(ifa.tecla_presionada), 0);
      chk("mrst_lib", int'(ifa.tecla_liberada), 0);
      rst = 1'b0;
      ciclos(80);
      chk("mrst_presses", q_a.size() - bq, 2);
      chk("mrst_recode", q_a[q_a.size()-1], 5);
      chk("mrst_norel", rel_a - br, 0);
      soltar_a(1, 1, 0, 0);
      chk("mrst_rel", rel_a - br, 1);

      // Randomized single-key presses with press and release bounce
      for (int k = 0; k < 6; k++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         bq = q_a.size(); br = rel_a;
         nb = $urandom_range(0, 2);
         for (int j = 0; j < nb; j++) begin
            keys_a[r][c] = 1'b1;
            ciclos($urandom_range(1, 7));
            keys_a[r][c] = 1'b0;
            ciclos($urandom_range(1, 5));
         end
         keys_a[r][c] = 1'b1;
         ciclos($urandom_range(60, 120));
         chk("rnd_a_presses", q_a.size() - bq, 1);
         chk("rnd_a_code", (q_a.size() > bq) ? q_a[q_a.size()-1] : -1, r * 4 + c);
         chk("rnd_a_pres", int'(ifa.tecla_presionada), 1);
         h = $urandom_range(0, 6);
         l = $urandom_range(1, 3);
         soltar_a(r, c, h, l);
         chk("rnd_a_rel", rel_a - br, 1);
         chk("rnd_a_presses2", q_a.size() - bq, 1);
         chk("rnd_a_code_hold", int'(ifa.tecla_codigo), r * 4 + c);
      end

      // 2x3 fast-scan instance: row 1 / col 2 -> code 5
      bq = q_b.size(); br = rel_b;
      keys_b[1][2] = 1'b1;
      ciclos(60);
      chk("b5_presses", q_b.size() - bq, 1);
      chk("b5_code", int'(ifb.tecla_codigo), 5);
      chk("b5_pres", int'(ifb.tecla_presionada), 1);
      soltar_b(1, 2, 0, 0);
      chk("b5_rel", rel_b - br, 1);
      chk("b5_pres_off", int'(ifb.tecla_presionada), 0);

      for (int k = 0; k < 5; k++) begin
         r = $urandom_range(0, 1);
         c = $urandom_range(0, 2);
         bq = q_b.size(); br = rel_b;
         keys_b[r][c] = 1'b1;
         ciclos($urandom_range(50, 90));
         chk("rnd_b_presses", q_b.size() - bq, 1);
         chk("rnd_b_code", (q_b.size() > bq) ? q_b[q_b.size()-1] : -1, r * 3 + c);
         soltar_b(r, c, $urandom_range(0, 6), $urandom_range(1, 3));
         chk("rnd_b_rel", rel_b - br, 1);
         chk("rnd_b_presses2", q_b.size() - bq, 1);
      end

      chk("viol_a", viol_a, 0);
      chk("viol_b", viol_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
